// File: rtl/i2c_master.sv
// i2c_master: single-master I2C engine moving one address byte plus one data byte (write or read)
module i2c_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic [6:0] sensorAddr_I2C,
  input  logic [7:0] writeVal_I2C,
  input  logic       mode_I2C,
  input  logic       start_I2C,
  output logic [7:0] readVal_I2C,
  output logic       dataRdy_I2C,
  output logic       nack_I2C,
  output logic       scl_I2C,
  output logic       sda_oe_I2C,
  input  logic       sda_in_I2C
);
  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);
  typedef enum logic [2:0] {IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP, DONE} state_t;
  state_t     state_q, state_d;
  logic [7:0] div_q, div_d, sh_q, sh_d, data_q, data_d, rd_q, rd_d;
  logic [1:0] qtr_q, qtr_d;
  logic [2:0] bit_q, bit_d;
  logic       mode_q, mode_d, pend_q, pend_d, nack_q, nack_d;
  logic       busy, qend, samp, bend;
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    data_d  = data_q;
    rd_d    = rd_q;
    bit_d   = bit_q;
    mode_d  = mode_q;
    pend_d  = pend_q;
    nack_d  = nack_q;
    busy    = state_q != IDLE && state_q != DONE;
    qend    = busy && div_q == DIV_MAX;
    samp    = qend && qtr_q == 2'd2;
    bend    = qend && qtr_q == 2'd3;
    div_d   = busy ? (qend ? 8'd0 : div_q + 8'd1) : 8'd0;
    qtr_d   = busy ? qtr_q + 2'(qend) : 2'd0;
    case (state_q)
      IDLE: if (start_I2C) begin
        state_d = START;
        sh_d    = {sensorAddr_I2C, mode_I2C};
        data_d  = writeVal_I2C;
        mode_d  = mode_I2C;
        pend_d  = 1'b0;
      end
      START: if (bend) state_d = ADDR;
      ADDR: if (bend) begin
        sh_d    = {sh_q[6:0], 1'b0};
        bit_d   = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? ADDR_ACK : ADDR;
      end
      ADDR_ACK: begin
        if (samp) pend_d = sda_in_I2C;
        if (bend) begin
          state_d = pend_q ? STOP : DATA;
          sh_d    = data_q;
        end
      end
      DATA: begin
        if (samp && mode_q) sh_d = {sh_q[6:0], sda_in_I2C};
        if (bend) begin
          if (!mode_q) sh_d = {sh_q[6:0], 1'b0};
          bit_d   = bit_q + 3'd1;
          state_d = bit_q == 3'd7 ? DATA_ACK : DATA;
        end
      end
      DATA_ACK: begin
        if (samp && !mode_q) pend_d = sda_in_I2C;
        if (bend) state_d = STOP;
      end
      STOP: if (bend) begin
        state_d = DONE;
        nack_d  = pend_q;
        if (mode_q && !pend_q) rd_d = sh_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      mode_q  <= 1'b0;
      pend_q  <= 1'b0;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      nack_q  <= nack_d;
    end
  end
  // STOP raises SCL one quarter early so SDA is released while SCL is already high
  always_comb begin
    scl_I2C = (state_q == IDLE || state_q == DONE) ? 1'b1 :
              (state_q == START) ? qtr_q != 2'd3 :
              (state_q == STOP) ? qtr_q != 2'd0 : qtr_q[1];
    sda_oe_I2C = (state_q == START) ? qtr_q[1] :
                 (state_q == STOP) ? !qtr_q[1] :
                 (state_q == ADDR || (state_q == DATA && !mode_q)) ? !sh_q[7] : 1'b0;
  end
  assign readVal_I2C = rd_q;
  assign nack_I2C    = nack_q;
  assign dataRdy_I2C = state_q == DONE;
endmodule
